// File: rtl/match_reporter_if.sv
// match_reporter_if: byte-wide valid/ready read port between match_reporter and the host.
//   rd_data  : current output byte (driven by master)
//   rd_valid : rd_data is valid (driven by master)
//   rd_ready : host accepts the byte on rd_valid & rd_ready (driven by slave)
interface match_reporter_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/match_reporter.sv
// match_reporter: captures matching keys into a small FIFO and serializes them, LSB byte first,
// over a valid/ready read port. Also keeps a saturating match counter and a sticky overflow flag.
//   CLK         : clock, rising edge
//   reset       : synchronous, active-high reset
//   Din         : candidate key, captured when good is high
//   good        : match strobe
//   rd          : read port (rd_data / rd_valid out, rd_ready in)
//   pending     : keys waiting in the FIFO (not counting the one being serialized)
//   match_count : saturating count of good cycles
//   overflow    : sticky, set when a key is dropped because the FIFO is full
module match_reporter #(
  parameter int unsigned width      = 63,
  parameter int unsigned depth_log2 = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [width:0]        Din,
  input  logic                  good,
  match_reporter_if.master      rd,
  output logic [depth_log2:0]   pending,
  output logic [15:0]           match_count,
  output logic                  overflow
);

  localparam int unsigned Depth  = 2 ** depth_log2;
  localparam int unsigned NBytes = (width + 1) / 8;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam int unsigned CntW   = depth_log2 + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q;
  logic [width:0]        mem_q [Depth];
  logic [depth_log2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       cnt_q;
  logic [width:0]        shift_q;
  logic [IdxW-1:0]       idx_q;
  logic                  valid_q;
  logic [15:0]           match_cnt_q;
  logic                  ovf_q;

  logic fifo_full, fifo_empty, push, pop, handshake, last_byte;

  always_comb begin
    fifo_full  = (cnt_q == CntW'(Depth));
    fifo_empty = (cnt_q == '0);
    // Full test uses current occupancy only; a same-cycle pop does not make room.
    push       = good & ~fifo_full;
    handshake  = valid_q & rd.rd_ready;
    last_byte  = (idx_q == IdxW'(NBytes - 1));
    // Pop when idle, or when the last byte of the current key is accepted (back-to-back keys).
    pop        = ~fifo_empty & ((state_q == StIdle) | (handshake & last_byte));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      match_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= Din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (good) begin
        if (match_cnt_q != 16'hFFFF) begin
          match_cnt_q <= match_cnt_q + 16'd1;
        end
        if (fifo_full) begin
          ovf_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            idx_q   <= '0;
            valid_q <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (handshake) begin
            if (!last_byte) begin
              shift_q <= shift_q >> 8;
              idx_q   <= idx_q + 1'b1;
            end else if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              idx_q   <= '0;
            end else begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd.rd_data   = shift_q[7:0];
  assign rd.rd_valid  = valid_q;
  assign pending      = cnt_q;
  assign match_count  = match_cnt_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/match_reporter.md
# match_reporter

Drains match results from the comparer stage toward the host. Each cycle `good` is high, the candidate key on `Din` is captured into a small FIFO. Captured keys are then serialized as bytes over a valid/ready read port, which the host-side I/O logic polls. The block also keeps a saturating match counter and a sticky overflow flag, so no match is ever lost silently.

## Interface
Parameters:
- `width`, 63: MSB index of the key bus; key is `width+1` bits; `width+1` must be a multiple of 8.
- `depth_log2`, 2: FIFO holds `2**depth_log2` keys.

Ports:
- `CLK`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Din`  in  width+1  candidate key, registered and aligned with `good`.
- `good`  in  1  match strobe; one key captured per high cycle.
- `rd_data`  out  8  current output byte.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  host accepts byte when `rd_valid & rd_ready`.
- `pending`  out  depth_log2+1  keys held in FIFO, excluding the key being serialized.
- `match_count`  out  16  total matches seen; saturates at 16'hFFFF.
- `overflow`  out  1  sticky; set when a match is dropped because the FIFO is full.

## Operation
- Reset values: `rd_data` 8'h00, `rd_valid` 0, `pending` 0, `match_count` 0, `overflow` 0, FIFO pointers 0, state IDLE.
- Push: `good` high and FIFO not full → write `Din` at the write pointer; increment the write pointer.
- Full test: uses the current-cycle occupancy only. A pop in the same cycle does not make room.
- `good` high while full → key dropped; `overflow` set to 1.
- `overflow` clears only on `reset`.
- `match_count` increments on every `good` cycle, including dropped matches, until it saturates.
- Pointers wrap modulo `2**depth_log2`. Occupancy is tracked with a `depth_log2+1`-bit counter.
- Simultaneous push and pop → occupancy unchanged.
- State machine, 2 states:
  - IDLE: `rd_valid`=0. If FIFO not empty, pop the head into a `width+1`-bit shift register, set byte index to 0, go to SEND.
  - SEND: `rd_valid`=1; `rd_data` is the low byte of the shift register. Bytes go out least-significant first.
  - SEND, on handshake, not the last byte: shift right by 8; increment byte index.
  - SEND, on handshake, last byte (index `(width+1)/8-1`), FIFO not empty: pop the next key in the same cycle; stay in SEND with index 0.
  - SEND, on handshake, last byte, FIFO empty: go to IDLE.
- No handshake while in SEND → `rd_data` and `rd_valid` hold stable.
- `reset` mid-transfer aborts the key being sent and empties the FIFO. The host must discard any partial key.

## Timing
- Latency from `good` to first byte: `good` high in cycle N → key written at the end of N.
  - Cycle N+1: IDLE sees the FIFO non-empty and pops.
  - Cycle N+2: `rd_valid`=1 with byte 0.
- `pending` reflects a push one cycle after `good`.
- With `rd_ready` held high, a 64-bit key takes 8 consecutive cycles.
- Back-to-back keys: no idle cycle between the last byte of one key and byte 0 of the next.
- `match_count` updates one cycle after `good`.
- `overflow` rises one cycle after the dropped `good`.
- All outputs are registered.

## Test plan
- Single match, `rd_ready`=1. Pulse `good` with `Din`=64'h0123456789ABCDEF in cycle 10.
  - Bytes EF,CD,AB,89,67,45,23,01 appear in cycles 12–19.
  - `rd_valid` falls in cycle 20.
  - `match_count`=1.
- Backpressure: same key, but `rd_ready` is low for cycles 12–15.
  - `rd_data`=EF and `rd_valid`=1 hold through cycle 15.
  - The sequence resumes intact from cycle 16.
- Burst and overflow, `depth_log2`=2, `rd_ready`=0. Drive `good` for 6 consecutive cycles with keys 1..6.
  - Key 1 is in the shift register; keys 2..5 are in the FIFO; `pending`=4.
  - Key 6 is dropped; `overflow`=1; `match_count`=6.
  - After raising `rd_ready`, keys 1–5 come out back-to-back, 40 bytes with no gap.
- Simultaneous push and pop: push a key in the same cycle the last byte of the previous key is accepted.
  - Both keys are delivered; `pending` stays consistent; no byte is lost or duplicated.
- Reset mid-transfer: assert `reset` after 3 bytes of a key with 2 more keys queued.
  - Next cycle: `rd_valid`=0, `pending`=0, `match_count`=0, `overflow`=0.
  - A subsequent match serializes correctly from byte 0.
- Counter saturation: preload by driving 65540 `good` pulses with `rd_ready`=1.
  - `match_count` stays at 16'hFFFF.
